// File: rtl/burst_memory.sv
// burst_memory: byte-addressed, big-endian simulation memory with
// registered 1/4/8/16-word read and write bursts.
module burst_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
);
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BPW);
    localparam int OW    = $clog2(DEPTH);
    localparam int IW    = OW - LB;
    localparam int WORDS = DEPTH / BPW;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t state, state_next;

    // Word-granular storage: the byte at the lowest offset is the MSB.
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [IW-1:0] idx, idx_next, req_idx, mem_widx;
    logic [4:0]    count, count_next, req_len;
    logic          accept, mem_we, rd_beat;
    logic          unused_addr;

    // Subtracting only the in-range bits gives the offset modulo DEPTH.
    assign req_idx     = address[OW-1:LB] - START_ADDR[OW-1:LB];
    assign unused_addr = ^{address[ADDR_WIDTH-1:OW], address[LB-1:0]};

    always_comb begin
        req_len = 5'd1;
        case (access_size)
            2'b00:   req_len = 5'd1;
            2'b01:   req_len = 5'd4;
            2'b10:   req_len = 5'd8;
            default: req_len = 5'd16;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (rw)                    state_next = RD_BURST;
                    else if (req_len != 5'd1) state_next = WR_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (count == 5'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept     = (state == IDLE) && enable;
        mem_we     = !reset && ((accept && !rw) || (state == WR_BURST));
        mem_widx   = accept ? req_idx : idx;
        rd_beat    = (state == RD_BURST);
        idx_next   = idx;
        count_next = count;
        if (accept) begin
            // A write consumes word 0 on the accept edge itself.
            idx_next   = rw ? req_idx : req_idx + IW'(1);
            count_next = rw ? req_len : req_len - 5'd1;
        end else if (state != IDLE) begin
            idx_next   = idx + IW'(1);
            count_next = count - 5'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            count      <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            idx        <= idx_next;
            count      <= count_next;
            busy       <= (state_next != IDLE);
            data_valid <= rd_beat;
            if (rd_beat) data_out <= mem[idx];
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_widx] <= data_in;
    end

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: table-driven, hand-written and randomized bursts
// checked against a byte-level big-endian reference model.
module tb_burst_memory;
    localparam int DEPTH = 1048576;
    localparam logic [31:0] START = 32'h80020000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;

    always #5 clock = ~clock;

    burst_memory #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH(DEPTH),
        .START_ADDR(START)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .data_in(data_in),
        .access_size(access_size),
        .rw(rw),
        .enable(enable),
        .busy(busy),
        .data_out(data_out),
        .data_valid(data_valid)
    );

    typedef struct {
        logic        r;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] d0;
        int          exp_busy;
        int          exp_valid;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t        tbl [10];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mb [int];
    logic [31:0] beats [$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    function automatic int base_off(input logic [31:0] a);
        logic [31:0] d;
        d = (a - START) & 32'(DEPTH - 1);
        d = d & ~32'h3;
        return int'(d);
    endfunction

    function automatic int len(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] beat(input int i);
        if (i < beats.size()) return beats[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic model_write(input int off, input logic [31:0] w);
        for (int b = 0; b < 4; b++) mb[(off + b) % DEPTH] = w[31-8*b -: 8];
    endtask

    task automatic model_word(input int off, output logic [31:0] w,
                              output logic known);
        w = '0;
        known = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (mb.exists((off + b) % DEPTH)) w = {w[23:0], mb[(off + b) % DEPTH]};
            else known = 1'b0;
        end
    endtask

    // One burst with per-cycle busy/valid checks; word k of a write is d0*(k+1).
    task automatic burst(input logic r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d0,
                         input int poke, output int nbusy, output int nvalid);
        int          n;
        int          base;
        logic [31:0] w;
        logic        known;
        logic        eb;
        logic        ev;
        n = len(sz);
        base = base_off(a);
        nbusy = 0;
        nvalid = 0;
        beats.delete();
        @(negedge clock);
        enable = 1'b1;
        rw = r;
        access_size = sz;
        address = a;
        data_in = d0;
        if (!r) model_write(base, d0);
        @(posedge clock);
        for (int j = 0; j <= n + 1; j++) begin
            @(negedge clock);
            eb = r ? (j < n) : (j < n - 1);
            ev = r && (j >= 1) && (j <= n);
            check("busy", 32'(busy), 32'(eb));
            check("data_valid", 32'(data_valid), 32'(ev));
            if (busy) nbusy++;
            if (data_valid) begin
                nvalid++;
                beats.push_back(data_out);
            end
            if (ev && data_valid) begin
                model_word((base + 4 * (j - 1)) % DEPTH, w, known);
                if (known) check("read_beat", data_out, w);
            end
            enable = (j + 1 == poke);
            address = a ^ 32'h100;
            rw = 1'b1;
            access_size = 2'b00;
            if (!r && (j + 1 < n)) begin
                data_in = d0 * (j + 2);
                model_write((base + 4 * (j + 1)) % DEPTH, data_in);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        int          nb;
        int          nv;
        logic [31:0] ra;
        logic [31:0] rd;
        logic [1:0]  rs;

        enable = 1'b0;
        rw = 1'b1;
        access_size = 2'b00;
        address = START;
        data_in = '0;

        tbl[0] = '{1'b0, 2'd0, 32'h80020000, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 2'd0, 32'h80020000, 32'h0, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 2'd1, 32'h80020010, 32'h11111111, 3, 0, 32'h0, 32'h0};
        tbl[3] = '{1'b1, 2'd1, 32'h80020010, 32'h0, 4, 4, 32'h11111111, 32'h44444444};
        tbl[4] = '{1'b1, 2'd0, 32'h80020003, 32'h0, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 2'd0, 32'h80020013, 32'h0, 1, 1, 32'h11111111, 32'h11111111};
        tbl[6] = '{1'b0, 2'd0, 32'h80120020, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0};
        tbl[7] = '{1'b1, 2'd0, 32'h80020020, 32'h0, 1, 1, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[8] = '{1'b0, 2'd2, 32'h80020040, 32'h01020304, 7, 0, 32'h0, 32'h0};
        tbl[9] = '{1'b1, 2'd2, 32'h80020040, 32'h0, 8, 8, 32'h01020304, 32'h08101820};

        #12;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_data", data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            burst(tbl[i].r, tbl[i].sz, tbl[i].addr, tbl[i].d0, -1, nb, nv);
            check("busy_cycles", 32'(nb), 32'(tbl[i].exp_busy));
            check("valid_cycles", 32'(nv), 32'(tbl[i].exp_valid));
            if (tbl[i].r) begin
                check("first_beat", beat(0), tbl[i].exp_first);
                check("last_beat", beat(nv - 1), tbl[i].exp_last);
            end
        end

        check("byte0", 32'(dut.mem[0][31:24]), 32'hDE);
        check("byte3", 32'(dut.mem[0][7:0]), 32'hEF);

        // Back-to-back single writes, one per cycle.
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1;
            rw = 1'b0;
            access_size = 2'b00;
            address = START + 32'h200 + 32'(4 * i);
            data_in = 32'hB0B00000 + 32'(i);
            model_write(base_off(address), data_in);
            @(negedge clock);
            check("b2b_busy", 32'(busy), 32'h0);
        end
        enable = 1'b0;
        burst(1'b1, 2'b01, START + 32'h200, 32'h0, -1, nb, nv);
        check("b2b_beats", 32'(nv), 32'd4);
        check("b2b_last", beat(3), 32'hB0B00003);

        // Second request at E2 of an 8-word read must be dropped.
        burst(1'b1, 2'b10, START + 32'h40, 32'h0, 2, nb, nv);
        check("poke_busy", 32'(nb), 32'd8);
        check("poke_beats", 32'(nv), 32'd8);
        check("poke_last", beat(7), 32'h08101820);

        // Reset after the third beat of an 8-word read.
        @(negedge clock);
        enable = 1'b1;
        rw = 1'b1;
        access_size = 2'b10;
        address = START + 32'h40;
        @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pre_valid", 32'(data_valid), 32'h1);
        check("rst_pre_data", data_out, 32'h0306090C);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_data", data_out, 32'h0);
        enable = 1'b1;
        rw = 1'b0;
        data_in = 32'hBADBAD00;
        access_size = 2'b00;
        @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
        check("rst_hold_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        burst(1'b1, 2'b00, START + 32'h40, 32'h0, -1, nb, nv);
        check("rst_after_beats", 32'(nv), 32'd1);
        check("rst_after_data", beat(0), 32'h01020304);

        // 16-word burst across the top of memory.
        burst(1'b0, 2'b11, 32'h8011FFF8, 32'h00A50001, -1, nb, nv);
        check("wrap_wr_busy", 32'(nb), 32'd15);
        burst(1'b1, 2'b11, 32'h8011FFF8, 32'h0, -1, nb, nv);
        check("wrap_rd_beats", 32'(nv), 32'd16);
        check("wrap_beat0", beat(0), 32'h00A50001);
        check("wrap_beat1", beat(1), 32'h014A0002);
        check("wrap_beat2", beat(2), 32'h01EF0003);
        burst(1'b1, 2'b00, START, 32'h0, -1, nb, nv);
        check("wrap_off0", beat(0), 32'h01EF0003);

        for (int it = 0; it < 24; it++) begin
            ra = START + 32'h1000 + 32'($urandom_range(0, 32'hFFF));
            if ($urandom_range(0, 1) == 1) ra = ra + 32'(DEPTH) * 32'($urandom_range(1, 3));
            rs = 2'($urandom_range(0, 3));
            rd = $urandom;
            burst(1'b0, rs, ra, rd, -1, nb, nv);
            burst(1'b1, rs, ra, 32'h0, -1, nb, nv);
            check("rnd_beats", 32'(nv), 32'(len(rs)));
            check("rnd_first", beat(0), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
